// File: rtl/karatsuba_gf2_sequencer.sv
// Sequential one-level Karatsuba carry-less multiplier over GF(2).
// A single bit-serial H x H engine is reused for the hh, ll and mid products.
module karatsuba_gf2_sequencer #(
   parameter int N = 571
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] c
);

   localparam int L   = N / 2;
   localparam int H   = N - L;
   localparam int W   = 2 * N;
   localparam int P   = 2 * H - 1;
   localparam int LLW = 2 * L - 1;
   localparam int IW  = $clog2(H + 1);

   localparam logic [IW-1:0] H_LAST = IW'(H - 1);
   localparam logic [IW-1:0] L_LAST = IW'(L - 1);
   localparam logic [IW-1:0] ONE    = IW'(1);

   typedef enum logic [2:0] {
      IDLE,
      P_HH,
      P_LL,
      P_MID,
      COMBINE
   } state_t;

   state_t          state;
   logic [N-1:0]    a_q;
   logic [N-1:0]    b_q;
   logic [P-1:0]    mc;
   logic [H-1:0]    mp;
   logic [P-1:0]    acc;
   logic [IW-1:0]   idx;
   logic [P-1:0]    hh;
   logic [LLW-1:0]  ll;
   logic [P-1:0]    mm;

   logic [P-1:0]    acc_nxt;
   logic [H-1:0]    mid_a;
   logic [H-1:0]    mid_b;
   logic [W-1:0]    c_nxt;

   // Engine step, mid-operand sums and the final Karatsuba recombination.
   always_comb begin
      acc_nxt = acc ^ (mp[0] ? mc : '0);
      mid_a   = a_q[N-1:L] ^ H'(a_q[L-1:0]);
      mid_b   = b_q[N-1:L] ^ H'(b_q[L-1:0]);
      c_nxt   = (W'(hh) << (2 * L))
              ^ (W'(mm ^ hh ^ P'(ll)) << L)
              ^ W'(ll);
   end

   // Sequencer: walks the three sub-products then publishes c with a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         c     <= '0;
         a_q   <= '0;
         b_q   <= '0;
         mc    <= '0;
         mp    <= '0;
         acc   <= '0;
         idx   <= '0;
         hh    <= '0;
         ll    <= '0;
         mm    <= '0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     a_q   <= a;
                     b_q   <= b;
                     mc    <= P'(a[N-1:L]);
                     mp    <= b[N-1:L];
                     acc   <= '0;
                     idx   <= '0;
                     busy  <= 1'b1;
                     state <= P_HH;
                  end
               end
               P_HH: begin
                  acc <= acc_nxt;
                  mc  <= mc << 1;
                  mp  <= mp >> 1;
                  idx <= idx + ONE;
                  if (idx == H_LAST) begin
                     hh    <= acc_nxt;
                     acc   <= '0;
                     idx   <= '0;
                     mc    <= P'(a_q[L-1:0]);
                     mp    <= H'(b_q[L-1:0]);
                     state <= P_LL;
                  end
               end
               P_LL: begin
                  acc <= acc_nxt;
                  mc  <= mc << 1;
                  mp  <= mp >> 1;
                  idx <= idx + ONE;
                  if (idx == L_LAST) begin
                     ll    <= acc_nxt[LLW-1:0];
                     acc   <= '0;
                     idx   <= '0;
                     mc    <= P'(mid_a);
                     mp    <= mid_b;
                     state <= P_MID;
                  end
               end
               P_MID: begin
                  acc <= acc_nxt;
                  mc  <= mc << 1;
                  mp  <= mp >> 1;
                  idx <= idx + ONE;
                  if (idx == H_LAST) begin
                     mm    <= acc_nxt;
                     idx   <= '0;
                     state <= COMBINE;
                  end
               end
               COMBINE: begin
                  c     <= c_nxt;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
